clk_div_cfg: RTL and testbench

Configurable integer clock divider sitting directly downstream of the reset synchronizer: it consumes the synchronized, active-high reset and the reference clock, and produces a divided clock for slower domains (e.g. serial link oversampling clock). Ratio and enable are software-driven and take effect only at divided-clock period boundaries, so the output never produces runt pulses while running. When disabled or configured with a ratio below 2, the reference clock is passed through.

---
 rtl/clk_div_cfg.sv | 105 ++++++++++
 tb/tb_clk_div_cfg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_cfg.sv
// Configurable integer clock divider with period-boundary reconfiguration.
// Ratios below 2, or a disabled divider, pass the reference clock through.
module clk_div_cfg #(
  parameter int RATIO_WD = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clk_en,
  input  logic [RATIO_WD-1:0] i_div_ratio,
  output logic                o_div_clk,
  output logic                o_div_rise,
  output logic [RATIO_WD-1:0] o_act_ratio
);

  // state  | meaning
  // S_IDLE | bypass: i_clk passed through, no ratio latched
  // S_LOW  | low phase of a divided period, ceil(N/2) cycles
  // S_HIGH | high phase of a divided period, floor(N/2) cycles
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  localparam int CNT_WD = RATIO_WD - 1;

  state_t              r_state;
  logic [CNT_WD-1:0]   r_cnt;
  logic                r_div;
  logic                r_rise;
  logic [RATIO_WD-1:0] r_ratio;

  logic [RATIO_WD-1:0] w_cnt_ext;
  logic [RATIO_WD-1:0] w_low_last;
  logic [RATIO_WD-1:0] w_high_last;
  logic                w_req_run;

  // Phase limits come from the latched ratio only, so mid-period writes never
  // disturb the running period.
  assign w_cnt_ext   = {1'b0, r_cnt};
  assign w_low_last  = (r_ratio - RATIO_WD'(1)) >> 1;
  assign w_high_last = (r_ratio >> 1) - RATIO_WD'(1);
  assign w_req_run   = i_clk_en && (i_div_ratio >= RATIO_WD'(2));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_rise  <= 1'b0;
      r_ratio <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rise <= 1'b0;
          if (w_req_run) begin
            r_ratio <= i_div_ratio;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_state <= S_LOW;
          end
        end
        S_LOW: begin
          if (w_cnt_ext == w_low_last) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
            r_div   <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_WD'(1);
          end
        end
        S_HIGH: begin
          r_rise <= 1'b0;
          if (w_cnt_ext == w_high_last) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            if (w_req_run) begin
              r_ratio <= i_div_ratio;
              r_state <= S_LOW;
            end else begin
              r_ratio <= '0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_WD'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_div   <= 1'b0;
          r_rise  <= 1'b0;
          r_ratio <= '0;
        end
      endcase
    end
  end

  // Reset gates the bypass mux so downstream logic sees a quiet clock.
  assign o_div_clk   = i_rst ? 1'b0 : ((r_state == S_IDLE) ? i_clk : r_div);
  assign o_div_rise  = r_rise & ~i_rst;
  assign o_act_ratio = i_rst ? '0 : r_ratio;

endmodule

// File: tb/tb_clk_div_cfg.sv
// Scoreboard bench for clk_div_cfg: a period-position reference model feeds
// expected outputs into a queue that an independent monitor drains.
module tb_clk_div_cfg;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic [7:0] div_ratio;
  logic       div_clk;
  logic       div_rise;
  logic [7:0] act_ratio;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       div_hi;
    logic       div_lo;
    logic       rise;
    logic [7:0] act;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: running flag, ratio in effect and position within period.
  bit running = 0;
  int m_n     = 0;
  int m_pos   = 0;

  clk_div_cfg #(.RATIO_WD(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .o_div_clk   (div_clk),
    .o_div_rise  (div_rise),
    .o_act_ratio (act_ratio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    exp_t e;
    bit   want;
    int   low_len;
    want = clk_en && (div_ratio >= 8'd2);
    if (rst) begin
      running = 0;
    end else if (!running) begin
      if (want) begin
        running = 1;
        m_n     = int'(div_ratio);
        m_pos   = 0;
      end
    end else if (m_pos == m_n - 1) begin
      if (want) begin
        m_n   = int'(div_ratio);
        m_pos = 0;
      end else begin
        running = 0;
      end
    end else begin
      m_pos = m_pos + 1;
    end
    low_len = (m_n + 1) / 2;
    if (rst) begin
      e.div_hi = 1'b0; e.div_lo = 1'b0; e.rise = 1'b0; e.act = 8'd0;
    end else if (!running) begin
      e.div_hi = 1'b1; e.div_lo = 1'b0; e.rise = 1'b0; e.act = 8'd0;
    end else begin
      e.div_hi = (m_pos >= low_len);
      e.div_lo = e.div_hi;
      e.rise   = (m_pos == low_len);
      e.act    = 8'(m_n);
    end
    #1;
    exp_q.push_back(e);
  end

  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (div_clk !== e.div_hi) begin
        errors++;
        $display("FAIL div_clk_hi t=%0t got %b want %b", $time, div_clk, e.div_hi);
      end
      checks++;
      if (div_rise !== e.rise) begin
        errors++;
        $display("FAIL div_rise t=%0t got %b want %b", $time, div_rise, e.rise);
      end
      checks++;
      if (act_ratio !== e.act) begin
        errors++;
        $display("FAIL act_ratio t=%0t got %0d want %0d", $time, act_ratio, e.act);
      end
      @(negedge clk);
      #2;
      checks++;
      if (div_clk !== (rst ? 1'b0 : e.div_lo)) begin
        errors++;
        $display("FAIL div_clk_lo t=%0t got %b want %b", $time, div_clk,
                 rst ? 1'b0 : e.div_lo);
      end
    end
  end

  task automatic drive(input logic en, input logic [7:0] r, input logic rs, input int n);
    @(negedge clk);
    clk_en    = en;
    div_ratio = r;
    rst       = rs;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    rst       = 1'b1;
    clk_en    = 1'b1;
    div_ratio = 8'd4;

    drive(1, 8'd4, 1, 3);
    drive(1, 8'd4, 0, 12);
    drive(1, 8'd5, 0, 20);
    drive(1, 8'd3, 0, 12);
    drive(1, 8'd2, 0, 8);
    drive(1, 8'd6, 0, 14);
    drive(1, 8'd3, 0, 10);
    drive(1, 8'd8, 0, 18);
    drive(0, 8'd8, 0, 12);
    drive(1, 8'd1, 0, 6);
    drive(1, 8'd0, 0, 3);
    drive(1, 8'd7, 0, 12);
    drive(1, 8'd7, 1, 2);
    drive(1, 8'd7, 0, 16);
    drive(1, 8'd255, 0, 520);
    drive(0, 8'd255, 0, 260);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       r = 8'($urandom_range(0, 1));
        1:       r = 8'($urandom_range(200, 255));
        default: r = 8'($urandom_range(2, 12));
      endcase
      drive($urandom_range(0, 9) != 0, r, $urandom_range(0, 40) == 0,
            $urandom_range(1, 12));
    end

    repeat (3) @(posedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
